// File: rtl/predecode_queue_if.sv
// predecode_queue_if: fetch-batch input and rename-slot output bundle of the pre-decode queue
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef ALU_TYPE_INT
`define ALU_TYPE_INT 2'd0
`define ALU_TYPE_MUL 2'd1
`define ALU_TYPE_MEM 2'd2
`define ALU_TYPE_FO 2'd3
`endif
interface predecode_queue_if #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int GHR_BITS = `BP_GHR_BITS
);
  localparam int CW = $clog2(LANES + 1);
  localparam int OW = $clog2(DEPTH + 1);
  logic flush;
  logic [LANES-1:0] in_valid;
  logic [LANES*32-1:0] in_inst;
  logic [LANES*32-1:0] in_pc;
  logic [LANES-1:0] in_pred_taken;
  logic [LANES*32-1:0] in_pred_target;
  logic [LANES*GHR_BITS-1:0] in_pred_hist;
  logic in_ready;
  logic [LANES-1:0] out_valid;
  logic [LANES*32-1:0] out_inst;
  logic [LANES*32-1:0] out_pc;
  logic [LANES-1:0] out_pred_taken;
  logic [LANES*32-1:0] out_pred_target;
  logic [LANES*GHR_BITS-1:0] out_pred_hist;
  logic [LANES*2-1:0] out_fu_type;
  logic [LANES*5-1:0] out_rs1;
  logic [LANES*5-1:0] out_rs2;
  logic [LANES*5-1:0] out_rd;
  logic [LANES*32-1:0] out_imm;
  logic [LANES-1:0] out_use_imm;
  logic [LANES-1:0] out_rs1_is_fp;
  logic [LANES-1:0] out_rs2_is_fp;
  logic [LANES-1:0] out_rd_is_fp;
  logic [CW-1:0] out_pop_cnt;
  logic [OW-1:0] occupancy;
  modport master (
    output flush, in_valid, in_inst, in_pc, in_pred_taken, in_pred_target, in_pred_hist, out_pop_cnt,
    input in_ready, out_valid, out_inst, out_pc, out_pred_taken, out_pred_target, out_pred_hist,
    input out_fu_type, out_rs1, out_rs2, out_rd, out_imm, out_use_imm,
    input out_rs1_is_fp, out_rs2_is_fp, out_rd_is_fp, occupancy
  );
  modport slave (
    input flush, in_valid, in_inst, in_pc, in_pred_taken, in_pred_target, in_pred_hist, out_pop_cnt,
    output in_ready, out_valid, out_inst, out_pc, out_pred_taken, out_pred_target, out_pred_hist,
    output out_fu_type, out_rs1, out_rs2, out_rd, out_imm, out_use_imm,
    output out_rs1_is_fp, out_rs2_is_fp, out_rd_is_fp, occupancy
  );
endinterface

// File: rtl/predecode_queue.sv
// predecode_queue: decodes a holey LANES-wide fetch batch and compacts it into a circular queue feeding rename
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif
`ifndef ALU_TYPE_INT
`define ALU_TYPE_INT 2'd0
`define ALU_TYPE_MUL 2'd1
`define ALU_TYPE_MEM 2'd2
`define ALU_TYPE_FO 2'd3
`endif
module predecode_queue #(
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int GHR_BITS = `BP_GHR_BITS
) (
  input logic clk,
  input logic rst,
  predecode_queue_if.slave q
);
  localparam int CW = $clog2(LANES + 1);
  localparam int OW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [6:0] OPC_LOAD = 7'h03, OPC_LOAD_FP = 7'h07, OPC_MISC_MEM = 7'h0f;
  localparam logic [6:0] OPC_OP_IMM = 7'h13, OPC_AUIPC = 7'h17, OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_STORE_FP = 7'h27, OPC_OP = 7'h33, OPC_LUI = 7'h37;
  localparam logic [6:0] OPC_MADD = 7'h43, OPC_MSUB = 7'h47, OPC_NMSUB = 7'h4b, OPC_NMADD = 7'h4f;
  localparam logic [6:0] OPC_OP_FP = 7'h53, OPC_BRANCH = 7'h63, OPC_JALR = 7'h67;
  localparam logic [6:0] OPC_JAL = 7'h6f, OPC_SYSTEM = 7'h73;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic taken;
    logic [31:0] target;
    logic [GHR_BITS-1:0] hist;
    logic [1:0] fu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [31:0] imm;
    logic use_imm;
    logic rs1_fp;
    logic rs2_fp;
    logic rd_fp;
  } entry_t;
  localparam entry_t EMPTY = '{fu: `ALU_TYPE_INT, default: '0};
  function automatic entry_t decode(input logic [31:0] i);
    entry_t e;
    logic [6:0] op;
    logic fused, op_fp, i_t, s_t, b_t, u_t, j_t, z_t;
    op = i[6:0];
    fused = op inside {OPC_MADD, OPC_MSUB, OPC_NMSUB, OPC_NMADD};
    op_fp = op == OPC_OP_FP;
    i_t = op inside {OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM};
    s_t = op == OPC_STORE;
    b_t = op == OPC_BRANCH;
    u_t = op inside {OPC_LUI, OPC_AUIPC};
    j_t = op == OPC_JAL;
    z_t = op == OPC_SYSTEM && i[14];
    e = EMPTY;
    e.inst = i;
    e.fu = (op == OPC_OP && i[31:25] == 7'b0000001) ? `ALU_TYPE_MUL :
           (op inside {OPC_LOAD, OPC_STORE, OPC_MISC_MEM}) ? `ALU_TYPE_MEM :
           (fused || op_fp || op inside {OPC_LOAD_FP, OPC_STORE_FP}) ? `ALU_TYPE_FO : `ALU_TYPE_INT;
    e.rs1 = (u_t || j_t || z_t) ? 5'd0 : i[19:15];
    e.rs2 = (fused || op_fp || op inside {OPC_OP, OPC_BRANCH, OPC_STORE, OPC_STORE_FP}) ? i[24:20] : 5'd0;
    e.rd = (op inside {OPC_STORE, OPC_STORE_FP, OPC_BRANCH}) ? 5'd0 : i[11:7];
    e.imm = i_t ? {{20{i[31]}}, i[31:20]} :
            s_t ? {{20{i[31]}}, i[31:25], i[11:7]} :
            b_t ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
            u_t ? {i[31:12], 12'b0} :
            j_t ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
            z_t ? {27'b0, i[19:15]} : 32'b0;
    e.use_imm = i_t || s_t || b_t || u_t || j_t || z_t;
    e.rs1_fp = fused || op_fp;
    e.rs2_fp = fused || op_fp || op == OPC_STORE_FP;
    e.rd_fp = fused || op_fp || op == OPC_LOAD_FP;
    return e;
  endfunction
  entry_t mem [DEPTH];
  entry_t dec [LANES];
  entry_t slot [LANES];
  logic [AW-1:0] wr_idx [LANES];
  logic [AW-1:0] head, tail;
  logic [OW-1:0] occ;
  logic [CW-1:0] n_enq, n_avail, n_pop;
  logic do_enq;
  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    n_enq = '0;
    for (int l = 0; l < LANES; l++) begin
      wr_idx[l] = tail + AW'(n_enq);
      n_enq = n_enq + CW'(q.in_valid[l]);
      dec[l] = decode(q.in_inst[32*l +: 32]);
      dec[l].pc = q.in_pc[32*l +: 32];
      dec[l].taken = q.in_pred_taken[l];
      dec[l].target = q.in_pred_target[32*l +: 32];
      dec[l].hist = q.in_pred_hist[GHR_BITS*l +: GHR_BITS];
    end
  end
  assign q.in_ready = occ <= OW'(DEPTH - LANES);
  assign q.occupancy = occ;
  assign do_enq = q.in_ready && |q.in_valid && !q.flush;
  assign n_avail = (occ < OW'(LANES)) ? CW'(occ) : CW'(LANES);
  assign n_pop = (q.out_pop_cnt < n_avail) ? q.out_pop_cnt : n_avail;
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      head <= '0;
      tail <= '0;
      occ <= '0;
    end else begin
      head <= head + AW'(n_pop);
      tail <= do_enq ? tail + AW'(n_enq) : tail;
      occ <= occ + (do_enq ? OW'(n_enq) : OW'(0)) - OW'(n_pop);
    end
  end
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (do_enq && q.in_valid[l]) mem[wr_idx[l]] <= dec[l];
  end
  always_comb begin
    for (int s = 0; s < LANES; s++) begin
      q.out_valid[s] = OW'(s) < occ;
      slot[s] = q.out_valid[s] ? mem[head + AW'(s)] : EMPTY;
      q.out_inst[32*s +: 32] = slot[s].inst;
      q.out_pc[32*s +: 32] = slot[s].pc;
      q.out_pred_taken[s] = slot[s].taken;
      q.out_pred_target[32*s +: 32] = slot[s].target;
      q.out_pred_hist[GHR_BITS*s +: GHR_BITS] = slot[s].hist;
      q.out_fu_type[2*s +: 2] = slot[s].fu;
      q.out_rs1[5*s +: 5] = slot[s].rs1;
      q.out_rs2[5*s +: 5] = slot[s].rs2;
      q.out_rd[5*s +: 5] = slot[s].rd;
      q.out_imm[32*s +: 32] = slot[s].imm;
      q.out_use_imm[s] = slot[s].use_imm;
      q.out_rs1_is_fp[s] = slot[s].rs1_fp;
      q.out_rs2_is_fp[s] = slot[s].rs2_fp;
      q.out_rd_is_fp[s] = slot[s].rd_fp;
    end
  end
  // Rename must never pop more than it is shown; the datapath clamps regardless.
  pop_in_range: assert property (@(posedge clk) disable iff (rst) q.out_pop_cnt <= n_avail);
endmodule

// File: tb/tb_predecode_queue.sv
// tb_predecode_queue: directed and random stimulus against a queue-of-decoded-entries reference model
module tb_predecode_queue;
  localparam int L = 2, D = 8, G = 8;
  localparam logic [1:0] FU_INT = 2'd0, FU_MUL = 2'd1, FU_MEM = 2'd2, FU_FO = 2'd3;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic taken;
    logic [31:0] target;
    logic [G-1:0] hist;
    logic [1:0] fu;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [31:0] imm;
    logic use_imm;
    logic rs1_fp;
    logic rs2_fp;
    logic rd_fp;
  } ent_t;
  logic clk = 0;
  logic rst = 1;
  predecode_queue_if #(.LANES(L), .DEPTH(D), .GHR_BITS(G)) bus ();
  predecode_queue #(.LANES(L), .DEPTH(D), .GHR_BITS(G)) dut (.clk(clk), .rst(rst), .q(bus));
  always #5 clk = ~clk;
  ent_t model [$];
  int vectors = 0, errors = 0;
  logic [31:0] li [L], lp [L], lt [L];
  logic lk [L];
  logic [G-1:0] lh [L];
  logic [31:0] pc_seq = 32'h1000;
  function automatic ent_t ref_decode(input logic [31:0] i, pc, tgt, input logic tk, input logic [G-1:0] h);
    ent_t e;
    logic [6:0] op;
    byte fmt;
    logic fpa;
    e = '0;
    op = i[6:0];
    fpa = op inside {7'h53, 7'h43, 7'h47, 7'h4b, 7'h4f};
    e.inst = i; e.pc = pc; e.target = tgt; e.taken = tk; e.hist = h;
    case (op)
      7'h33: e.fu = (i[31:25] == 7'd1) ? FU_MUL : FU_INT;
      7'h03, 7'h23, 7'h0f: e.fu = FU_MEM;
      7'h07, 7'h27, 7'h53, 7'h43, 7'h47, 7'h4b, 7'h4f: e.fu = FU_FO;
      default: e.fu = FU_INT;
    endcase
    case (op)
      7'h13, 7'h03, 7'h67, 7'h0f: fmt = "I";
      7'h23: fmt = "S";
      7'h63: fmt = "B";
      7'h37, 7'h17: fmt = "U";
      7'h6f: fmt = "J";
      7'h73: fmt = i[14] ? "Z" : "-";
      default: fmt = "-";
    endcase
    case (fmt)
      "I": e.imm = $signed(i) >>> 20;
      "S": e.imm = $signed({i[31:25], i[11:7], 20'b0}) >>> 20;
      "B": e.imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 19'b0}) >>> 19;
      "U": e.imm = i & 32'hffff_f000;
      "J": e.imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 11'b0}) >>> 11;
      "Z": e.imm = {27'b0, i[19:15]};
      default: e.imm = 0;
    endcase
    e.use_imm = fmt != "-";
    e.rs1 = (op inside {7'h37, 7'h17, 7'h6f} || fmt == "Z") ? 5'd0 : i[19:15];
    e.rs2 = (fpa || op inside {7'h33, 7'h63, 7'h23, 7'h27}) ? i[24:20] : 5'd0;
    e.rd = (op inside {7'h23, 7'h27, 7'h63}) ? 5'd0 : i[11:7];
    e.rs1_fp = fpa;
    e.rs2_fp = fpa || op == 7'h27;
    e.rd_fp = fpa || op == 7'h07;
    return e;
  endfunction
  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [18] = '{7'h03, 7'h07, 7'h0f, 7'h13, 7'h17, 7'h23, 7'h27, 7'h33, 7'h37,
                              7'h43, 7'h47, 7'h4b, 7'h4f, 7'h53, 7'h63, 7'h67, 7'h6f, 7'h73};
    logic [31:0] r;
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 17)];
    if (r[6:0] == 7'h33 && $urandom_range(0, 1) == 1) r[31:25] = 7'd1;
    return r;
  endfunction
  task automatic rand_lanes();
    for (int l = 0; l < L; l++) begin
      li[l] = rand_inst(); lp[l] = pc_seq; lt[l] = $urandom;
      lk[l] = 1'($urandom); lh[l] = G'($urandom); pc_seq += 4;
    end
  endtask
  task automatic cmp(input string tag, input logic [255:0] got, input logic [255:0] want);
    vectors++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask
  task automatic check(input string tag);
    ent_t exp, obs;
    cmp({tag, ".occ"}, 256'(bus.occupancy), 256'(model.size()));
    cmp({tag, ".ready"}, 256'(bus.in_ready), 256'((D - model.size()) >= L));
    for (int s = 0; s < L; s++) begin
      exp = (s < model.size()) ? model[s] : '0;
      obs.inst = bus.out_inst[32*s +: 32]; obs.pc = bus.out_pc[32*s +: 32];
      obs.taken = bus.out_pred_taken[s]; obs.target = bus.out_pred_target[32*s +: 32];
      obs.hist = bus.out_pred_hist[G*s +: G]; obs.fu = bus.out_fu_type[2*s +: 2];
      obs.rs1 = bus.out_rs1[5*s +: 5]; obs.rs2 = bus.out_rs2[5*s +: 5]; obs.rd = bus.out_rd[5*s +: 5];
      obs.imm = bus.out_imm[32*s +: 32]; obs.use_imm = bus.out_use_imm[s];
      obs.rs1_fp = bus.out_rs1_is_fp[s]; obs.rs2_fp = bus.out_rs2_is_fp[s]; obs.rd_fp = bus.out_rd_is_fp[s];
      cmp($sformatf("%s.valid%0d", tag, s), 256'(bus.out_valid[s]), 256'(s < model.size()));
      cmp($sformatf("%s.slot%0d", tag, s), 256'(obs), 256'(exp));
    end
  endtask
  // One clock: drive the batch, step the model as the queue should step, then check.
  task automatic cycle(input logic [L-1:0] v, input int pop, input logic fl, input string tag);
    int n;
    bit rdy;
    for (int l = 0; l < L; l++) begin
      bus.in_inst[32*l +: 32] = li[l]; bus.in_pc[32*l +: 32] = lp[l];
      bus.in_pred_target[32*l +: 32] = lt[l]; bus.in_pred_taken[l] = lk[l];
      bus.in_pred_hist[G*l +: G] = lh[l];
    end
    bus.in_valid = v; bus.out_pop_cnt = 2'(pop); bus.flush = fl;
    @(posedge clk);
    if (rst || fl) model.delete();
    else begin
      rdy = (D - model.size()) >= L;
      n = (pop < model.size()) ? pop : model.size();
      if (n > L) n = L;
      repeat (n) void'(model.pop_front());
      if (rdy)
        for (int l = 0; l < L; l++)
          if (v[l]) model.push_back(ref_decode(li[l], lp[l], lt[l], lk[l], lh[l]));
    end
    #1;
    check(tag);
  endtask
  int popped;
  logic [31:0] next_pc;
  initial begin
    rand_lanes();
    cycle('0, 0, 0, "rst0");
    cycle('0, 0, 0, "rst1");
    rst = 0;
    cycle('0, 0, 0, "idle");
    rand_lanes();
    li[0] = 32'hffd08293; li[1] = 32'h00612423;
    cycle(2'b11, 0, 0, "addi_sw");
    cmp("addi.rd", 256'(bus.out_rd[4:0]), 256'(5));
    cmp("addi.rs1", 256'(bus.out_rs1[4:0]), 256'(1));
    cmp("addi.imm", 256'(bus.out_imm[31:0]), 256'(32'hffff_fffd));
    cmp("sw.rs2", 256'(bus.out_rs2[9:5]), 256'(6));
    cmp("sw.imm", 256'(bus.out_imm[63:32]), 256'(8));
    cmp("sw.fu", 256'(bus.out_fu_type[3:2]), 256'(FU_MEM));
    cycle('0, 2, 0, "drain0");
    rand_lanes();
    li[1] = 32'h025201b3; lp[1] = 32'h200;
    cycle(2'b10, 0, 0, "hole");
    cmp("hole.valid", 256'(bus.out_valid), 256'(2'b01));
    cmp("hole.fu", 256'(bus.out_fu_type[1:0]), 256'(FU_MUL));
    cmp("hole.pc", 256'(bus.out_pc[31:0]), 256'(32'h200));
    cycle('0, 1, 0, "drain1");
    for (int k = 0; k < 5; k++) begin
      rand_lanes();
      cycle(2'b11, 0, 0, "fill");
    end
    cmp("full.occ", 256'(bus.occupancy), 256'(8));
    cmp("full.ready", 256'(bus.in_ready), 256'(0));
    rand_lanes();
    cycle(2'b11, 2, 0, "pop2");
    cmp("pop2.occ", 256'(bus.occupancy), 256'(6));
    cmp("pop2.ready", 256'(bus.in_ready), 256'(1));
    repeat (3) cycle('0, 2, 0, "drain2");
    popped = 0;
    next_pc = 32'h8000;
    for (int k = 0; k < 60 && popped < 20; k++) begin
      rand_lanes();
      lp[0] = 32'h8000 + 32'(k) * 4;
      if (model.size() > 0) begin
        cmp("wrap.pc", 256'(bus.out_pc[31:0]), 256'(next_pc));
        next_pc += 4;
        popped++;
      end
      cycle((k < 20) ? 2'b01 : 2'b00, (model.size() > 0) ? 1 : 0, 0, "wrap");
    end
    cmp("wrap.count", 256'(popped), 256'(20));
    rand_lanes(); cycle(2'b11, 0, 0, "f0");
    rand_lanes(); cycle(2'b11, 0, 0, "f1");
    rand_lanes(); cycle(2'b01, 0, 0, "f2");
    cmp("preflush.occ", 256'(bus.occupancy), 256'(5));
    rand_lanes(); cycle(2'b11, 0, 1, "flush");
    cmp("flush.occ", 256'(bus.occupancy), 256'(0));
    cmp("flush.valid", 256'(bus.out_valid), 256'(0));
    rand_lanes();
    li[0] = 32'h3408d3f3; li[1] = 32'h203100c3;
    cycle(2'b11, 0, 0, "csr_fma");
    cmp("csr.rs1", 256'(bus.out_rs1[4:0]), 256'(0));
    cmp("csr.imm", 256'(bus.out_imm[31:0]), 256'(17));
    cmp("csr.use_imm", 256'(bus.out_use_imm[0]), 256'(1));
    cmp("fma.fp", 256'({bus.out_rs1_is_fp[1], bus.out_rs2_is_fp[1], bus.out_rd_is_fp[1]}), 256'(3'b111));
    cmp("fma.fu", 256'(bus.out_fu_type[3:2]), 256'(FU_FO));
    for (int k = 0; k < 400; k++) begin
      int avail;
      avail = (model.size() < L) ? model.size() : L;
      rand_lanes();
      cycle(L'($urandom), $urandom_range(0, avail), $urandom_range(0, 19) == 0, "rand");
    end
    rand_lanes(); cycle(2'b11, 0, 0, "pre_rst0");
    rand_lanes(); cycle(2'b11, 0, 0, "pre_rst1");
    rst = 1;
    rand_lanes(); cycle(2'b11, 1, 0, "midrst");
    rst = 0;
    cmp("midrst.occ", 256'(bus.occupancy), 256'(0));
    cmp("midrst.valid", 256'(bus.out_valid), 256'(0));
    cmp("midrst.ready", 256'(bus.in_ready), 256'(1));
    cmp("midrst.imm", 256'(bus.out_imm), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
